frame_interp_sequencer: RTL and testbench
=========================================

Name: frame_interp_sequencer

Overview:
Sequences the combinational frame_interpolator_averaging datapath over a streamed frame. Accepts each line group of the current frame and fetches the co-located group of the previous frame from the frame store. Emits either the averaged (interpolated) group, or the current group as a bypass, then writes the current group back to the store. Sits between the HDMI input line packer and the upscaler output path.

Parameters:
BIT_DEPTH, 8, bits per colour channel
ROW_WIDTH, 2, pixels per line in a group
N_LINES, 2, lines per group
GROUPS_PER_FRAME, 540, line groups per frame
GW, N_LINES*ROW_WIDTH*3*BIT_DEPTH (derived), packed group width; layout [line][pixel][colour][bit], colour 0=R, 1=G, 2=B
AW, $clog2(GROUPS_PER_FRAME) (derived), frame-store address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1=interpolate when a previous frame is valid; 0=force bypass
in_valid  in  1  input group valid
in_ready  out  1  sequencer can accept a group
in_sof  in  1  group is first of a frame
in_data  in  GW  current-frame group
rd_req  out  1  one-cycle frame-store read strobe
rd_addr  out  AW  read group address
rd_valid  in  1  read data valid (>=1 cycle after rd_req)
rd_data  in  GW  previous-frame group
wr_en  out  1  frame-store write request, held until wr_ready
wr_ready  in  1  store accepts write
wr_addr  out  AW  write group address
wr_data  out  GW  current group written back
out_valid  out  1  output group valid
out_ready  in  1  downstream accepts
out_data  out  GW  interpolated or bypassed group
out_sof  out  1  out_data is first group of frame
out_interp  out  1  1=averaged, 0=bypass
frame_err  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset: state IDLE. All outputs 0, except in_ready=1 in the cycle after reset deasserts. grp_cnt=0, prev_valid=0, internal registers 0. Reset mid-operation abandons the group. No write is issued and the store contents are treated as invalid.
- IDLE: in_ready=1.
  - On in_valid&in_ready, capture in_data and in_sof. Address = in_sof ? 0 : grp_cnt.
  - If in_sof and grp_cnt!=0: pulse frame_err and clear prev_valid.
  - If prev_valid&enable: go to RD_REQ. Otherwise load out_data=in_data, out_interp=0, and go to EMIT.
- RD_REQ: rd_req=1 for exactly one cycle with rd_addr=address; go to RD_WAIT.
- RD_WAIT: wait for rd_valid. The averager sees scanline_in_last=rd_data and scanline_in_current=captured group. On rd_valid, register its scanline_out into out_data, set out_interp=1, go to EMIT. An rd_valid outside RD_WAIT is ignored.
- EMIT: out_valid=1, and out_data/out_sof/out_interp are held stable. On out_ready, go to WR the next cycle.
- WR: wr_en=1 with wr_addr=address and wr_data=captured group, held until wr_ready. On wr_en&wr_ready:
  - grp_cnt = address+1.
  - If address==GROUPS_PER_FRAME-1: grp_cnt=0 and prev_valid=1.
  - Go to IDLE.
- Groups beyond GROUPS_PER_FRAME without in_sof wrap the address to 0.
- in_ready=0 in every state except IDLE. At most one group is in flight.
- Latency from accept at cycle T:
  - Bypass: out_valid at T+1.
  - Interpolate: out_valid at T+2+d, where rd_valid arrives d>=1 cycles after rd_req (rd_req is at T+1).
- Averager contract, per channel: (a+b)>>1, computed with a 9-bit intermediate and truncated. The sequencer does not alter the data.
- enable is sampled only at accept time; changing it mid-group has no effect on that group.

Decomposition:
- Shared package frame_interp_pkg:
  - Packed group typedef parameterised by BIT_DEPTH, ROW_WIDTH and N_LINES.
  - State enum {IDLE, RD_REQ, RD_WAIT, EMIT, WR}.
  - Colour index constants R/G/B.
- Sub-module: one frame_interpolator_averaging instance, which is combinational. Everything else is inline FSM, counter and registers.

Test Plan (GROUPS_PER_FRAME=4):
1. Reset, enable=1, one frame of 4 all-255 groups (in_sof on the first) -> out_data all 255 and out_interp=0 each time. No rd_req. wr_addr 0,1,2,3. prev_valid=1 after the 4th write.
2. Next frame all-0 groups, with rd_data returning all-255 with d=2 -> rd_addr 0..3, out_data all 127, out_interp=1, out_valid 4 cycles after accept, out_sof only on the first group.
3. Prev red (255,0,0), cur blue (0,0,255) -> out (127,0,127). Prev grey 127, cur 127 -> 127.
4. out_ready low for 5 cycles in EMIT -> out_valid stays 1 and out_data is stable. in_ready=0 and wr_en=0 until out_ready rises. wr_ready low for 3 cycles holds wr_en=1 and wr_addr stable.
5. in_sof on the 3rd group of a frame -> frame_err pulses one cycle, address 0, prev_valid=0, and the following groups bypass (out_interp=0).
6. rst asserted during RD_WAIT -> next cycle all outputs 0 and a late rd_valid is ignored. No wr_en. The next frame's first group bypasses.

Source files
------------

// File: rtl/frame_interp_pkg.sv
// Shared types for the frame interpolation sequencer: packed line-group layout,
// sequencer states and the per-channel averaging rule.
`timescale 1ns/1ps
package frame_interp_pkg;

    localparam int BIT_DEPTH = 8;
    localparam int ROW_WIDTH = 2;
    localparam int N_LINES   = 2;
    localparam int N_COLOURS = 3;
    localparam int GW        = N_LINES * ROW_WIDTH * N_COLOURS * BIT_DEPTH;

    localparam int COL_R = 0;
    localparam int COL_G = 1;
    localparam int COL_B = 2;

    typedef logic [BIT_DEPTH-1:0] chan_t;
    typedef chan_t [N_COLOURS-1:0] pixel_t;
    typedef pixel_t [ROW_WIDTH-1:0] line_t;
    typedef line_t [N_LINES-1:0] group_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        EMIT    = 3'd3,
        WR      = 3'd4
    } state_t;

    // One extra bit keeps the carry so the halved sum is exact before truncation.
    function automatic chan_t avg_chan(input chan_t a, input chan_t b);
        logic [BIT_DEPTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[BIT_DEPTH:1];
    endfunction

endpackage

// File: rtl/frame_interpolator_averaging.sv
// Combinational temporal interpolator: every colour channel of the output group is
// the truncated mean of the co-located channels in the previous and current groups.
`timescale 1ns/1ps
module frame_interpolator_averaging
    import frame_interp_pkg::*;
(
    input  group_t scanline_in_last,
    input  group_t scanline_in_current,
    output group_t scanline_out
);

    always_comb begin
        scanline_out = '0;
        for (int l = 0; l < N_LINES; l++) begin
            for (int p = 0; p < ROW_WIDTH; p++) begin
                for (int c = COL_R; c <= COL_B; c++) begin
                    scanline_out[l][p][c] = avg_chan(scanline_in_last[l][p][c],
                                                     scanline_in_current[l][p][c]);
                end
            end
        end
    end

endmodule

// File: rtl/frame_interp_sequencer.sv
// Accepts one line group at a time, optionally averages it with the co-located group
// of the previous frame from the store, emits the result and writes the group back.
`timescale 1ns/1ps
module frame_interp_sequencer
    import frame_interp_pkg::*;
#(
    parameter int GROUPS_PER_FRAME = 540,
    parameter int AW               = $clog2(GROUPS_PER_FRAME)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [GW-1:0] in_data,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_valid,
    input  logic [GW-1:0] rd_data,
    output logic          wr_en,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [GW-1:0] wr_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [GW-1:0] out_data,
    output logic          out_sof,
    output logic          out_interp,
    output logic          frame_err
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and data is held stable while valid waits.
    localparam logic [AW-1:0] LAST_ADDR = AW'(GROUPS_PER_FRAME - 1);

    state_t        state;
    state_t        next_state;
    logic          live;
    logic [AW-1:0] addr;
    logic [AW-1:0] grp_cnt;
    logic          prev_valid;
    group_t        cur;
    group_t        avg_out;
    logic [GW-1:0] out_data_q;
    logic          out_sof_q;
    logic          out_interp_q;
    logic          frame_err_q;

    logic accept;
    logic sof_err;
    logic do_interp;

    assign accept    = in_valid & in_ready;
    // An early start of frame abandons the previous frame, so its store data is stale.
    assign sof_err   = in_sof & (grp_cnt != '0);
    assign do_interp = prev_valid & ~sof_err & enable;

    frame_interpolator_averaging u_avg (
        .scanline_in_last    (group_t'(rd_data)),
        .scanline_in_current (cur),
        .scanline_out        (avg_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = do_interp ? RD_REQ : EMIT;
            RD_REQ:  next_state = RD_WAIT;
            RD_WAIT: if (rd_valid) next_state = EMIT;
            EMIT:    if (out_ready) next_state = WR;
            WR:      if (wr_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) & live;
        rd_req    = (state == RD_REQ);
        wr_en     = (state == WR);
        out_valid = (state == EMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live         <= 1'b0;
            addr         <= '0;
            grp_cnt      <= '0;
            prev_valid   <= 1'b0;
            cur          <= '0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_interp_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            live        <= 1'b1;
            frame_err_q <= 1'b0;
            if (accept) begin
                cur       <= group_t'(in_data);
                out_sof_q <= in_sof;
                addr      <= in_sof ? '0 : grp_cnt;
                if (sof_err) begin
                    frame_err_q <= 1'b1;
                    prev_valid  <= 1'b0;
                end
                if (!do_interp) begin
                    out_data_q   <= in_data;
                    out_interp_q <= 1'b0;
                end
            end
            if (state == RD_WAIT && rd_valid) begin
                out_data_q   <= avg_out;
                out_interp_q <= 1'b1;
            end
            if (state == WR && wr_ready) begin
                if (addr == LAST_ADDR) begin
                    grp_cnt    <= '0;
                    prev_valid <= 1'b1;
                end else begin
                    grp_cnt <= addr + 1'b1;
                end
            end
        end
    end

    assign rd_addr    = addr;
    assign wr_addr    = addr;
    assign wr_data    = cur;
    assign out_data   = out_data_q;
    assign out_sof    = out_sof_q;
    assign out_interp = out_interp_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_frame_interp_sequencer.sv
// Bench for frame_interp_sequencer with a four-group frame: directed frames from the
// test plan followed by randomized frames, checked against a frame-level model.
`timescale 1ns/1ps
module tb_frame_interp_sequencer;
    import frame_interp_pkg::*;

    localparam int GPF = 4;
    localparam int AW  = 2;
    localparam int NB  = GW / BIT_DEPTH;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [GW-1:0] in_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [GW-1:0] rd_data;
    logic          wr_en;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [GW-1:0] wr_data;
    logic          out_valid;
    logic          out_ready;
    logic [GW-1:0] out_data;
    logic          out_sof;
    logic          out_interp;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    // Reference model: last completed group per frame position, position counter,
    // and whether a whole frame has been stored since the last break.
    logic [GW-1:0] m_frame [GPF];
    int            m_cnt;
    bit            m_prev;
    bit            m_en;
    logic [GW-1:0] exp_q [$];

    frame_interp_sequencer #(.GROUPS_PER_FRAME(GPF)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_interp (out_interp),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chkv(input string tag, input logic [GW-1:0] got, input logic [GW-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [GW-1:0] make_group(input logic [7:0] r, input logic [7:0] g,
                                                  input logic [7:0] b);
        logic [GW-1:0] v;
        v = '0;
        for (int i = 0; i < NB / 3; i++) v[i*24 +: 24] = {b, g, r};
        return v;
    endfunction

    function automatic logic [GW-1:0] avg_group(input logic [GW-1:0] a, input logic [GW-1:0] b);
        logic [GW-1:0] v;
        v = '0;
        for (int i = 0; i < NB; i++) v[i*8 +: 8] = 8'((int'(a[i*8 +: 8]) + int'(b[i*8 +: 8])) / 2);
        return v;
    endfunction

    function automatic logic [GW-1:0] rand_group();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Drives one group from IDLE through write-back; d is the read latency in cycles
    // after rd_req, ostall/wstall hold out_ready/wr_ready low for that many cycles.
    task automatic send_group(input logic [GW-1:0] data, input bit sof, input int d,
                              input int ostall, input int wstall);
        int            addr;
        bit            err;
        bit            interp;
        logic [GW-1:0] want;
        addr   = sof ? 0 : m_cnt;
        err    = sof && (m_cnt != 0);
        if (err) m_prev = 1'b0;
        interp = m_prev && m_en;
        exp_q.push_back(interp ? avg_group(m_frame[addr], data) : data);

        chkn("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = data;
        enable   = m_en;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = rand_group();
        enable   = 1'($urandom_range(0, 1));
        chkn("frame_err", 32'(frame_err), 32'(err));
        chkn("in_ready_busy", 32'(in_ready), 32'd0);
        if (interp) begin
            chkn("rd_req", 32'(rd_req), 32'd1);
            chkn("rd_addr", 32'(rd_addr), 32'(addr));
            for (int k = 2; k <= 1 + d; k++) begin
                @(negedge clk);
                chkn("rd_req_once", 32'(rd_req), 32'd0);
                chkn("out_valid_early", 32'(out_valid), 32'd0);
                if (k == 1 + d) begin
                    rd_valid = 1'b1;
                    rd_data  = m_frame[addr];
                end
            end
            @(negedge clk);
            rd_valid = 1'b0;
            rd_data  = rand_group();
        end else begin
            chkn("rd_req_bypass", 32'(rd_req), 32'd0);
            rd_valid = 1'b1;
            rd_data  = rand_group();
        end

        want = exp_q.pop_front();
        chkn("out_valid", 32'(out_valid), 32'd1);
        chkv("out_data", out_data, want);
        chkn("out_sof", 32'(out_sof), 32'(sof));
        chkn("out_interp", 32'(out_interp), 32'(interp));
        for (int s = 0; s < ostall; s++) begin
            @(negedge clk);
            rd_valid = 1'b0;
            chkn("out_valid_hold", 32'(out_valid), 32'd1);
            chkv("out_data_hold", out_data, want);
            chkn("in_ready_emit", 32'(in_ready), 32'd0);
            chkn("wr_en_emit", 32'(wr_en), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        rd_valid  = 1'b0;
        chkn("wr_en", 32'(wr_en), 32'd1);
        chkn("wr_addr", 32'(wr_addr), 32'(addr));
        chkv("wr_data", wr_data, data);
        chkn("out_valid_wr", 32'(out_valid), 32'd0);
        chkn("frame_err_clear", 32'(frame_err), 32'd0);
        for (int w = 0; w < wstall; w++) begin
            @(negedge clk);
            chkn("wr_en_hold", 32'(wr_en), 32'd1);
            chkn("wr_addr_hold", 32'(wr_addr), 32'(addr));
        end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        chkn("wr_en_done", 32'(wr_en), 32'd0);

        m_frame[addr] = data;
        if (addr == GPF - 1) begin
            m_cnt  = 0;
            m_prev = 1'b1;
        end else begin
            m_cnt = addr + 1;
        end
    endtask

    task automatic send_frame(input logic [GW-1:0] data, input int d);
        for (int g = 0; g < GPF; g++) send_group(data, g == 0, d, 0, 0);
    endtask

    initial begin
        logic [GW-1:0] g;
        rst       = 1'b1;
        enable    = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        wr_ready  = 1'b0;
        out_ready = 1'b0;
        m_cnt     = 0;
        m_prev    = 1'b0;
        m_en      = 1'b1;
        for (int i = 0; i < GPF; i++) m_frame[i] = '0;

        repeat (3) @(negedge clk);
        chkn("rst_in_ready", 32'(in_ready), 32'd0);
        chkn("rst_out_valid", 32'(out_valid), 32'd0);
        chkn("rst_rd_req", 32'(rd_req), 32'd0);
        chkn("rst_wr_en", 32'(wr_en), 32'd0);
        chkv("rst_out_data", out_data, '0);
        chkn("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        send_frame(make_group(8'd255, 8'd255, 8'd255), 1);
        send_frame(make_group(8'd0, 8'd0, 8'd0), 2);
        send_frame(make_group(8'd255, 8'd0, 8'd0), 1);
        send_group(make_group(8'd0, 8'd0, 8'd255), 1'b1, 3, 0, 0);
        send_group(make_group(8'd0, 8'd0, 8'd255), 1'b0, 2, 5, 3);
        send_group(make_group(8'd0, 8'd0, 8'd255), 1'b0, 1, 0, 0);
        send_group(make_group(8'd0, 8'd0, 8'd255), 1'b0, 1, 0, 0);
        send_frame(make_group(8'd127, 8'd127, 8'd127), 2);
        send_frame(make_group(8'd127, 8'd127, 8'd127), 1);

        // Truncated frame: start of frame arrives on the third group.
        send_group(rand_group(), 1'b1, 1, 0, 0);
        send_group(rand_group(), 1'b0, 2, 0, 0);
        send_group(rand_group(), 1'b1, 1, 0, 0);
        for (int i = 0; i < 3; i++) send_group(rand_group(), 1'b0, 1, 0, 0);

        m_en = 1'b0;
        for (int i = 0; i < GPF; i++) send_group(rand_group(), i == 0, 1, 0, 0);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < GPF + 1; i++) begin
                m_en = 1'($urandom_range(0, 1));
                send_group(rand_group(), (i == 0) || (i == GPF && f == 1), $urandom_range(1, 3),
                           $urandom_range(0, 2), $urandom_range(0, 2));
            end
        end
        m_en = 1'b1;
        send_frame(rand_group(), 1);

        // Reset while waiting for the store read.
        g = rand_group();
        chkn("in_ready_pre_rst", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = g;
        enable   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chkn("rd_req_pre_rst", 32'(rd_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chkn("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chkn("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chkn("mid_rst_rd_req", 32'(rd_req), 32'd0);
        chkn("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chkv("mid_rst_wr_data", wr_data, '0);
        chkv("mid_rst_out_data", out_data, '0);
        chkn("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        chkn("mid_rst_out_interp", 32'(out_interp), 32'd0);
        rst      = 1'b0;
        rd_valid = 1'b1;
        rd_data  = rand_group();
        @(negedge clk);
        rd_valid = 1'b0;
        chkn("post_rst_out_valid", 32'(out_valid), 32'd0);
        chkn("post_rst_wr_en", 32'(wr_en), 32'd0);
        chkn("post_rst_in_ready", 32'(in_ready), 32'd1);
        m_cnt  = 0;
        m_prev = 1'b0;

        for (int i = 0; i < GPF; i++) send_group(rand_group(), i == 0, 1, 0, 0);
        send_group(rand_group(), 1'b1, 2, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
